// File: rtl/rob_commit_unit.sv
// Reorder buffer with in-order commit, CDB completion, operand query forwarding
// and full flush on a branch mispredict discovered at commit.
module rob_commit_unit #(
    parameter int ROB_DEPTH = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,

    input  logic        in_issue_valid,
    input  logic [4:0]  in_issue_dest_reg,
    input  logic        in_issue_is_branch,
    input  logic        in_issue_pred_taken,
    output logic [3:0]  out_issue_rob,
    output logic        out_full,

    input  logic        in_cdb_valid,
    input  logic [3:0]  in_cdb_rob,
    input  logic [31:0] in_cdb_value,
    input  logic        in_cdb_taken,
    input  logic [31:0] in_cdb_target,

    input  logic [3:0]  in_query_rob1,
    input  logic [3:0]  in_query_rob2,
    output logic        out_query_ready1,
    output logic [31:0] out_query_value1,
    output logic        out_query_ready2,
    output logic [31:0] out_query_value2,

    output logic [4:0]  out_commit_reg,
    output logic [3:0]  out_commit_rob,
    output logic [31:0] out_commit_value,
    output logic        out_xbp,
    output logic [31:0] out_xbp_pc
);
    localparam logic [3:0] LAST_TAG = 4'(ROB_DEPTH);

    // Entry storage is indexed directly by tag; slot 0 is never allocated.
    logic [15:0] busy;
    logic [15:0] ready;
    logic [15:0] is_branch;
    logic [15:0] pred_taken;
    logic [15:0] taken;
    logic [4:0]  dest_reg [16];
    logic [31:0] value    [16];
    logic [31:0] target   [16];

    logic [3:0]  head;
    logic [3:0]  tail;
    logic [3:0]  count;

    logic        commit_fire;
    logic        mispredict;
    logic        issue_fire;
    logic        cdb_fire;
    logic        fwd1;
    logic        fwd2;

    function automatic logic [3:0] next_tag(input logic [3:0] t);
        return (t == LAST_TAG) ? 4'd1 : t + 4'd1;
    endfunction

    assign out_full      = (count == LAST_TAG);
    assign out_issue_rob = tail;

    // Issue handshake: an entry is taken on a cycle where in_issue_valid is high
    // and out_full is low (with rdy high and no flush); the issuer must hold its
    // request otherwise. Full is judged on registered count, so a same-cycle
    // commit never makes room for a same-cycle issue.
    always_comb begin
        commit_fire = rdy && busy[head] && ready[head];
        mispredict  = commit_fire && is_branch[head] && (taken[head] != pred_taken[head]);
        issue_fire  = rdy && in_issue_valid && !out_full && !mispredict;
        cdb_fire    = rdy && in_cdb_valid && (in_cdb_rob != 4'd0) &&
                      busy[in_cdb_rob] && !mispredict;
    end

    // Operand lookup: stored result first, then same-cycle CDB forward.
    assign fwd1 = in_cdb_valid && (in_cdb_rob == in_query_rob1);
    assign fwd2 = in_cdb_valid && (in_cdb_rob == in_query_rob2);

    assign out_query_ready1 = (in_query_rob1 != 4'd0) && (ready[in_query_rob1] || fwd1);
    assign out_query_value1 = (in_query_rob1 == 4'd0) ? 32'd0 :
                              ready[in_query_rob1]    ? value[in_query_rob1] :
                              fwd1                    ? in_cdb_value : 32'd0;
    assign out_query_ready2 = (in_query_rob2 != 4'd0) && (ready[in_query_rob2] || fwd2);
    assign out_query_value2 = (in_query_rob2 == 4'd0) ? 32'd0 :
                              ready[in_query_rob2]    ? value[in_query_rob2] :
                              fwd2                    ? in_cdb_value : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy       <= '0;
            ready      <= '0;
            is_branch  <= '0;
            pred_taken <= '0;
            taken      <= '0;
            for (int i = 0; i < 16; i++) begin
                dest_reg[i] <= '0;
                value[i]    <= '0;
                target[i]   <= '0;
            end
            head             <= 4'd1;
            tail             <= 4'd1;
            count            <= 4'd0;
            out_commit_reg   <= '0;
            out_commit_rob   <= '0;
            out_commit_value <= '0;
            out_xbp          <= 1'b0;
            out_xbp_pc       <= '0;
        end else begin
            out_commit_reg   <= commit_fire ? dest_reg[head] : 5'd0;
            out_commit_rob   <= commit_fire ? head : 4'd0;
            out_commit_value <= commit_fire ? value[head] : 32'd0;
            out_xbp          <= mispredict;
            out_xbp_pc       <= mispredict ? target[head] : 32'd0;

            if (mispredict) begin
                busy  <= '0;
                ready <= '0;
                head  <= 4'd1;
                tail  <= 4'd1;
                count <= 4'd0;
            end else begin
                if (cdb_fire) begin
                    ready[in_cdb_rob]  <= 1'b1;
                    value[in_cdb_rob]  <= in_cdb_value;
                    taken[in_cdb_rob]  <= in_cdb_taken;
                    target[in_cdb_rob] <= in_cdb_target;
                end
                if (issue_fire) begin
                    busy[tail]       <= 1'b1;
                    ready[tail]      <= 1'b0;
                    dest_reg[tail]   <= in_issue_dest_reg;
                    is_branch[tail]  <= in_issue_is_branch;
                    pred_taken[tail] <= in_issue_pred_taken;
                    tail             <= next_tag(tail);
                end
                // Placed after the CDB write so a broadcast to the retiring head
                // cannot leave a stale ready bit behind.
                if (commit_fire) begin
                    busy[head]  <= 1'b0;
                    ready[head] <= 1'b0;
                    head        <= next_tag(head);
                end
                case ({issue_fire, commit_fire})
                    2'b10:   count <= count + 4'd1;
                    2'b01:   count <= count - 4'd1;
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rob_commit_unit.sv
// Self-checking bench for rob_commit_unit: directed scenarios plus a randomized
// run against a program-order queue model of the reorder buffer.
module tb_rob_commit_unit;
    localparam int DEPTH = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        in_issue_valid;
    logic [4:0]  in_issue_dest_reg;
    logic        in_issue_is_branch;
    logic        in_issue_pred_taken;
    logic [3:0]  out_issue_rob;
    logic        out_full;
    logic        in_cdb_valid;
    logic [3:0]  in_cdb_rob;
    logic [31:0] in_cdb_value;
    logic        in_cdb_taken;
    logic [31:0] in_cdb_target;
    logic [3:0]  in_query_rob1;
    logic [3:0]  in_query_rob2;
    logic        out_query_ready1;
    logic [31:0] out_query_value1;
    logic        out_query_ready2;
    logic [31:0] out_query_value2;
    logic [4:0]  out_commit_reg;
    logic [3:0]  out_commit_rob;
    logic [31:0] out_commit_value;
    logic        out_xbp;
    logic [31:0] out_xbp_pc;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];

    // Reference model: entries by tag, in-flight tags in program order.
    bit          m_busy  [16];
    bit          m_ready [16];
    bit          m_br    [16];
    bit          m_pt    [16];
    bit          m_tk    [16];
    logic [4:0]  m_dest  [16];
    logic [31:0] m_val   [16];
    logic [31:0] m_tgt   [16];
    int          m_q[$];
    int          m_tail;

    logic [4:0]  e_reg;
    logic [3:0]  e_rob;
    logic [31:0] e_val;
    logic        e_xbp;
    logic [31:0] e_pc;

    rob_commit_unit #(.ROB_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .in_issue_valid(in_issue_valid), .in_issue_dest_reg(in_issue_dest_reg),
        .in_issue_is_branch(in_issue_is_branch), .in_issue_pred_taken(in_issue_pred_taken),
        .out_issue_rob(out_issue_rob), .out_full(out_full),
        .in_cdb_valid(in_cdb_valid), .in_cdb_rob(in_cdb_rob), .in_cdb_value(in_cdb_value),
        .in_cdb_taken(in_cdb_taken), .in_cdb_target(in_cdb_target),
        .in_query_rob1(in_query_rob1), .in_query_rob2(in_query_rob2),
        .out_query_ready1(out_query_ready1), .out_query_value1(out_query_value1),
        .out_query_ready2(out_query_ready2), .out_query_value2(out_query_value2),
        .out_commit_reg(out_commit_reg), .out_commit_rob(out_commit_rob),
        .out_commit_value(out_commit_value), .out_xbp(out_xbp), .out_xbp_pc(out_xbp_pc)
    );

    always #5 clk = ~clk;

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            m_busy[i]  = 1'b0;
            m_ready[i] = 1'b0;
        end
        m_q.delete();
        m_tail = 1;
    endtask

    // Applies one clock edge's worth of behaviour to the model and records the
    // registered outputs the DUT should show after that edge.
    task automatic model_step();
        int h;
        bit commit;
        bit misp;
        e_reg = '0; e_rob = '0; e_val = '0; e_xbp = 1'b0; e_pc = '0;
        if (rst) begin
            model_clear();
            return;
        end
        if (!rdy) return;
        commit = 1'b0;
        misp   = 1'b0;
        h      = 0;
        if (m_q.size() > 0) begin
            h      = m_q[0];
            commit = m_ready[h];
        end
        if (commit) begin
            e_reg = m_dest[h];
            e_rob = 4'(h);
            e_val = m_val[h];
            misp  = m_br[h] && (m_tk[h] != m_pt[h]);
            if (misp) begin
                e_xbp = 1'b1;
                e_pc  = m_tgt[h];
            end
        end
        if (misp) begin
            model_clear();
            return;
        end
        if (in_cdb_valid && in_cdb_rob != 4'd0 && m_busy[in_cdb_rob]) begin
            m_ready[in_cdb_rob] = 1'b1;
            m_val[in_cdb_rob]   = in_cdb_value;
            m_tk[in_cdb_rob]    = in_cdb_taken;
            m_tgt[in_cdb_rob]   = in_cdb_target;
        end
        if (in_issue_valid && m_q.size() < DEPTH) begin
            m_busy[m_tail]  = 1'b1;
            m_ready[m_tail] = 1'b0;
            m_dest[m_tail]  = in_issue_dest_reg;
            m_br[m_tail]    = in_issue_is_branch;
            m_pt[m_tail]    = in_issue_pred_taken;
            m_q.push_back(m_tail);
            m_tail = (m_tail % DEPTH) + 1;
        end
        if (commit) begin
            m_busy[h]  = 1'b0;
            m_ready[h] = 1'b0;
            void'(m_q.pop_front());
        end
    endtask

    function automatic logic [32:0] model_query(input int t);
        if (t == 0) return 33'd0;
        if (m_ready[t]) return {1'b1, m_val[t]};
        if (in_cdb_valid && int'(in_cdb_rob) == t) return {1'b1, in_cdb_value};
        return 33'd0;
    endfunction

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        rst = 1'b0; rdy = 1'b1;
        in_issue_valid = 1'b0; in_issue_dest_reg = '0;
        in_issue_is_branch = 1'b0; in_issue_pred_taken = 1'b0;
        in_cdb_valid = 1'b0; in_cdb_rob = '0; in_cdb_value = '0;
        in_cdb_taken = 1'b0; in_cdb_target = '0;
        in_query_rob1 = '0; in_query_rob2 = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst = 1'b1;
        advance();
        rst = 1'b0;
    endtask

    task automatic issue(input logic [4:0] dest, input logic br, input logic pt);
        in_issue_valid = 1'b1; in_issue_dest_reg = dest;
        in_issue_is_branch = br; in_issue_pred_taken = pt;
        advance();
        in_issue_valid = 1'b0; in_issue_is_branch = 1'b0; in_issue_pred_taken = 1'b0;
    endtask

    task automatic cdb(input logic [3:0] tag, input logic [31:0] val,
                       input logic tk, input logic [31:0] tgt);
        in_cdb_valid = 1'b1; in_cdb_rob = tag; in_cdb_value = val;
        in_cdb_taken = tk; in_cdb_target = tgt;
        advance();
        in_cdb_valid = 1'b0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        rdy = 1'b0;
        in_issue_valid = 1'b1;
        advance();
        advance();
        checks += 7;
        if (out_commit_reg !== 5'd0) begin errors++; $display("FAIL reset_commit_reg got %0d want 0", out_commit_reg); end
        if (out_commit_rob !== 4'd0) begin errors++; $display("FAIL reset_commit_rob got %0d want 0", out_commit_rob); end
        if (out_commit_value !== 32'd0) begin errors++; $display("FAIL reset_commit_value got %h want 0", out_commit_value); end
        if (out_xbp !== 1'b0) begin errors++; $display("FAIL reset_xbp got %b want 0", out_xbp); end
        if (out_xbp_pc !== 32'd0) begin errors++; $display("FAIL reset_xbp_pc got %h want 0", out_xbp_pc); end
        if (out_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", out_full); end
        if (out_issue_rob !== 4'd1) begin errors++; $display("FAIL reset_issue_rob got %0d want 1", out_issue_rob); end
        drive_idle();
    endtask

    task automatic test_basic_commit();
        do_reset();
        checks++;
        if (out_issue_rob !== 4'd1) begin errors++; $display("FAIL basic_first_tag got %0d want 1", out_issue_rob); end
        issue(5'd5, 1'b0, 1'b0);
        cdb(4'd1, 32'h1234, 1'b0, 32'd0);
        checks++;
        if (out_commit_rob !== 4'd0) begin errors++; $display("FAIL basic_early_commit got rob %0d want 0", out_commit_rob); end
        advance();
        checks += 3;
        if (out_commit_reg !== 5'd5) begin errors++; $display("FAIL basic_commit_reg got %0d want 5", out_commit_reg); end
        if (out_commit_rob !== 4'd1) begin errors++; $display("FAIL basic_commit_rob got %0d want 1", out_commit_rob); end
        if (out_commit_value !== 32'h1234) begin errors++; $display("FAIL basic_commit_value got %h want 1234", out_commit_value); end
        advance();
        checks += 2;
        if (out_commit_reg !== 5'd0) begin errors++; $display("FAIL basic_pulse_reg got %0d want 0", out_commit_reg); end
        if (out_commit_value !== 32'd0) begin errors++; $display("FAIL basic_pulse_value got %h want 0", out_commit_value); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 1; i <= DEPTH; i++) issue(5'(i), 1'b0, 1'b0);
        checks += 2;
        if (out_full !== 1'b1) begin errors++; $display("FAIL full_flag got %b want 1", out_full); end
        if (out_issue_rob !== 4'd1) begin errors++; $display("FAIL full_wrap_tag got %0d want 1", out_issue_rob); end
        issue(5'd20, 1'b0, 1'b0);
        checks += 2;
        if (out_full !== 1'b1) begin errors++; $display("FAIL full_extra_flag got %b want 1", out_full); end
        if (out_issue_rob !== 4'd1) begin errors++; $display("FAIL full_extra_tag got %0d want 1", out_issue_rob); end
        cdb(4'd1, 32'hA1, 1'b0, 32'd0);
        issue(5'd21, 1'b0, 1'b0);
        checks += 4;
        if (out_commit_rob !== 4'd1) begin errors++; $display("FAIL full_commit_rob got %0d want 1", out_commit_rob); end
        if (out_commit_value !== 32'hA1) begin errors++; $display("FAIL full_commit_value got %h want a1", out_commit_value); end
        if (out_issue_rob !== 4'd1) begin errors++; $display("FAIL full_issue_during_commit got tag %0d want 1", out_issue_rob); end
        if (out_full !== 1'b0) begin errors++; $display("FAIL full_after_commit got %b want 0", out_full); end
        issue(5'd22, 1'b0, 1'b0);
        checks += 2;
        if (out_issue_rob !== 4'd2) begin errors++; $display("FAIL full_reissue_tag got %0d want 2", out_issue_rob); end
        if (out_full !== 1'b1) begin errors++; $display("FAIL full_refill got %b want 1", out_full); end
    endtask

    task automatic test_in_order();
        do_reset();
        issue(5'd7, 1'b0, 1'b0);
        issue(5'd9, 1'b0, 1'b0);
        exp_q.push_back(32'h11);
        exp_q.push_back(32'h22);
        cdb(4'd2, 32'h22, 1'b0, 32'd0);
        advance();
        checks++;
        if (out_commit_rob !== 4'd0) begin errors++; $display("FAIL order_no_commit got rob %0d want 0", out_commit_rob); end
        cdb(4'd1, 32'h11, 1'b0, 32'd0);
        advance();
        checks += 3;
        if (out_commit_rob !== 4'd1) begin errors++; $display("FAIL order_first_rob got %0d want 1", out_commit_rob); end
        if (out_commit_reg !== 5'd7) begin errors++; $display("FAIL order_first_reg got %0d want 7", out_commit_reg); end
        if (out_commit_value !== exp_q[0]) begin errors++; $display("FAIL order_first_value got %h want %h", out_commit_value, exp_q[0]); end
        void'(exp_q.pop_front());
        advance();
        checks += 3;
        if (out_commit_rob !== 4'd2) begin errors++; $display("FAIL order_second_rob got %0d want 2", out_commit_rob); end
        if (out_commit_reg !== 5'd9) begin errors++; $display("FAIL order_second_reg got %0d want 9", out_commit_reg); end
        if (out_commit_value !== exp_q[0]) begin errors++; $display("FAIL order_second_value got %h want %h", out_commit_value, exp_q[0]); end
        void'(exp_q.pop_front());
        advance();
        checks++;
        if (out_commit_rob !== 4'd0) begin errors++; $display("FAIL order_idle got rob %0d want 0", out_commit_rob); end
    endtask

    task automatic test_mispredict();
        do_reset();
        issue(5'd1, 1'b0, 1'b0);
        issue(5'd2, 1'b0, 1'b0);
        issue(5'd3, 1'b1, 1'b0);
        cdb(4'd3, 32'h33, 1'b1, 32'h100);
        cdb(4'd1, 32'h11, 1'b0, 32'd0);
        cdb(4'd2, 32'h22, 1'b0, 32'd0);
        checks += 2;
        if (out_commit_rob !== 4'd1) begin errors++; $display("FAIL misp_commit1 got rob %0d want 1", out_commit_rob); end
        if (out_xbp !== 1'b0) begin errors++; $display("FAIL misp_early_xbp got %b want 0", out_xbp); end
        advance();
        in_issue_valid = 1'b1; in_issue_dest_reg = 5'd4;
        advance();
        in_issue_valid = 1'b0;
        checks += 7;
        if (out_xbp !== 1'b1) begin errors++; $display("FAIL misp_xbp got %b want 1", out_xbp); end
        if (out_xbp_pc !== 32'h100) begin errors++; $display("FAIL misp_xbp_pc got %h want 100", out_xbp_pc); end
        if (out_commit_reg !== 5'd3) begin errors++; $display("FAIL misp_commit_reg got %0d want 3", out_commit_reg); end
        if (out_commit_rob !== 4'd3) begin errors++; $display("FAIL misp_commit_rob got %0d want 3", out_commit_rob); end
        if (out_commit_value !== 32'h33) begin errors++; $display("FAIL misp_commit_value got %h want 33", out_commit_value); end
        if (out_issue_rob !== 4'd1) begin errors++; $display("FAIL misp_flush_tail got %0d want 1", out_issue_rob); end
        if (out_full !== 1'b0) begin errors++; $display("FAIL misp_flush_full got %b want 0", out_full); end
        advance();
        checks += 2;
        if (out_xbp !== 1'b0) begin errors++; $display("FAIL misp_pulse got %b want 0", out_xbp); end
        if (out_xbp_pc !== 32'd0) begin errors++; $display("FAIL misp_pc_idle got %h want 0", out_xbp_pc); end
    endtask

    task automatic test_forward();
        do_reset();
        for (int i = 0; i < 4; i++) issue(5'(10 + i), 1'b0, 1'b0);
        in_cdb_valid = 1'b1; in_cdb_rob = 4'd4; in_cdb_value = 32'hBEEF;
        in_query_rob1 = 4'd4; in_query_rob2 = 4'd3;
        #1;
        checks += 4;
        if (out_query_ready1 !== 1'b1) begin errors++; $display("FAIL fwd_ready got %b want 1", out_query_ready1); end
        if (out_query_value1 !== 32'hBEEF) begin errors++; $display("FAIL fwd_value got %h want beef", out_query_value1); end
        if (out_query_ready2 !== 1'b0) begin errors++; $display("FAIL fwd_pending_ready got %b want 0", out_query_ready2); end
        if (out_query_value2 !== 32'd0) begin errors++; $display("FAIL fwd_pending_value got %h want 0", out_query_value2); end
        advance();
        in_cdb_valid = 1'b0;
        in_query_rob2 = 4'd0;
        #1;
        checks += 3;
        if (out_query_ready1 !== 1'b1) begin errors++; $display("FAIL query_stored_ready got %b want 1", out_query_ready1); end
        if (out_query_value1 !== 32'hBEEF) begin errors++; $display("FAIL query_stored_value got %h want beef", out_query_value1); end
        if (out_query_ready2 !== 1'b0) begin errors++; $display("FAIL query_tag0_ready got %b want 0", out_query_ready2); end
        drive_idle();
    endtask

    task automatic test_rdy_freeze();
        do_reset();
        issue(5'd6, 1'b0, 1'b0);
        cdb(4'd1, 32'h66, 1'b0, 32'd0);
        rdy = 1'b0;
        in_issue_valid = 1'b1; in_issue_dest_reg = 5'd8;
        for (int i = 0; i < 3; i++) begin
            advance();
            checks += 3;
            if (out_commit_rob !== 4'd0) begin errors++; $display("FAIL freeze_commit_rob got %0d want 0", out_commit_rob); end
            if (out_commit_reg !== 5'd0) begin errors++; $display("FAIL freeze_commit_reg got %0d want 0", out_commit_reg); end
            if (out_issue_rob !== 4'd2) begin errors++; $display("FAIL freeze_tail got %0d want 2", out_issue_rob); end
        end
        rdy = 1'b1;
        in_issue_valid = 1'b0;
        advance();
        checks += 3;
        if (out_commit_rob !== 4'd1) begin errors++; $display("FAIL thaw_commit_rob got %0d want 1", out_commit_rob); end
        if (out_commit_reg !== 5'd6) begin errors++; $display("FAIL thaw_commit_reg got %0d want 6", out_commit_reg); end
        if (out_commit_value !== 32'h66) begin errors++; $display("FAIL thaw_commit_value got %h want 66", out_commit_value); end
        issue(5'd12, 1'b0, 1'b0);
        issue(5'd13, 1'b0, 1'b0);
        cdb(4'd2, 32'h77, 1'b0, 32'd0);
        rst = 1'b1;
        advance();
        rst = 1'b0;
        checks += 4;
        if (out_commit_rob !== 4'd0) begin errors++; $display("FAIL midrst_commit_rob got %0d want 0", out_commit_rob); end
        if (out_commit_value !== 32'd0) begin errors++; $display("FAIL midrst_commit_value got %h want 0", out_commit_value); end
        if (out_issue_rob !== 4'd1) begin errors++; $display("FAIL midrst_tail got %0d want 1", out_issue_rob); end
        if (out_full !== 1'b0) begin errors++; $display("FAIL midrst_full got %b want 0", out_full); end
    endtask

    task automatic test_random();
        logic [32:0] q1;
        logic [32:0] q2;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            rst = ($urandom_range(0, 99) == 0);
            rdy = ($urandom_range(0, 7) != 0);
            in_issue_valid      = ($urandom_range(0, 2) != 0);
            in_issue_dest_reg   = 5'($urandom_range(0, 31));
            in_issue_is_branch  = ($urandom_range(0, 5) == 0);
            in_issue_pred_taken = 1'($urandom_range(0, 1));
            in_cdb_valid  = ($urandom_range(0, 3) != 0);
            if (m_q.size() > 0 && $urandom_range(0, 3) != 0)
                in_cdb_rob = 4'(m_q[$urandom_range(0, m_q.size() - 1)]);
            else
                in_cdb_rob = 4'($urandom_range(0, 15));
            in_cdb_value  = $urandom;
            in_cdb_taken  = 1'($urandom_range(0, 1));
            in_cdb_target = $urandom;
            in_query_rob1 = ($urandom_range(0, 2) == 0) ? in_cdb_rob : 4'($urandom_range(0, 15));
            in_query_rob2 = 4'($urandom_range(0, 15));
            #1;
            q1 = model_query(int'(in_query_rob1));
            q2 = model_query(int'(in_query_rob2));
            checks += 6;
            if (out_full !== (m_q.size() == DEPTH)) begin errors++; $display("FAIL rnd_full cyc %0d got %b want %b", cyc, out_full, (m_q.size() == DEPTH)); end
            if (out_issue_rob !== 4'(m_tail)) begin errors++; $display("FAIL rnd_issue_rob cyc %0d got %0d want %0d", cyc, out_issue_rob, m_tail); end
            if (out_query_ready1 !== q1[32]) begin errors++; $display("FAIL rnd_q1_ready cyc %0d got %b want %b", cyc, out_query_ready1, q1[32]); end
            if (out_query_value1 !== q1[31:0]) begin errors++; $display("FAIL rnd_q1_value cyc %0d got %h want %h", cyc, out_query_value1, q1[31:0]); end
            if (out_query_ready2 !== q2[32]) begin errors++; $display("FAIL rnd_q2_ready cyc %0d got %b want %b", cyc, out_query_ready2, q2[32]); end
            if (out_query_value2 !== q2[31:0]) begin errors++; $display("FAIL rnd_q2_value cyc %0d got %h want %h", cyc, out_query_value2, q2[31:0]); end
            advance();
            checks += 5;
            if (out_commit_reg !== e_reg) begin errors++; $display("FAIL rnd_commit_reg cyc %0d got %0d want %0d", cyc, out_commit_reg, e_reg); end
            if (out_commit_rob !== e_rob) begin errors++; $display("FAIL rnd_commit_rob cyc %0d got %0d want %0d", cyc, out_commit_rob, e_rob); end
            if (out_commit_value !== e_val) begin errors++; $display("FAIL rnd_commit_value cyc %0d got %h want %h", cyc, out_commit_value, e_val); end
            if (out_xbp !== e_xbp) begin errors++; $display("FAIL rnd_xbp cyc %0d got %b want %b", cyc, out_xbp, e_xbp); end
            if (out_xbp_pc !== e_pc) begin errors++; $display("FAIL rnd_xbp_pc cyc %0d got %h want %h", cyc, out_xbp_pc, e_pc); end
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_basic_commit();
        test_full();
        test_in_order();
        test_mispredict();
        test_forward();
        test_rdy_freeze();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rob_commit_unit.md
ROB_COMMIT_UNIT -- requirements
Module: rob_commit_unit

Interface
REQ-001 SHALL have parameter ROB_DEPTH, default 15, number of entries; tags are 1..15, tag 0 means "no ROB entry".
REQ-002 SHALL have port clk  input  1  clock; reset rst, synchronous, active-high.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port rdy  input  1  global enable; low freezes all state.
REQ-005 SHALL have port in_issue_valid  input  1  allocate one entry this cycle.
REQ-006 SHALL have port in_issue_dest_reg  input  5  architectural destination; 0 = none.
REQ-007 SHALL have port in_issue_is_branch  input  1  entry is a control-flow instruction.
REQ-008 SHALL have port in_issue_pred_taken  input  1  fetch-time prediction.
REQ-009 SHALL have port out_issue_rob  output  4  tag the next issue will receive (current tail).
REQ-010 SHALL have port out_full  output  1  no free entry.
REQ-011 SHALL have ports in_cdb_valid (1), in_cdb_rob (4), in_cdb_value (32), in_cdb_taken (1), in_cdb_target (32), all inputs: completion broadcast with result, actual outcome and correct next PC.
REQ-012 SHALL have ports in_query_rob1/in_query_rob2  input  4, and out_query_ready1/2 (1), out_query_value1/2 (32) outputs: decoder operand lookup.
REQ-013 SHALL have ports out_commit_reg (5), out_commit_rob (4), out_commit_value (32), out_xbp (1), out_xbp_pc (32), all registered outputs to the register file and fetcher.

Function
REQ-014 SHALL hold per entry: busy, ready, dest_reg, value, is_branch, pred_taken, taken, target.
REQ-015 SHALL keep head, tail (range 1..15, increment 15->1 wrap) and count (0..15).
REQ-016 SHALL assert out_full combinationally when count == 15; out_issue_rob = tail.
REQ-017 Issue SHALL occur when in_issue_valid && !out_full && rdy && no flush this cycle: entry[tail] busy=1, ready=0, fields latched, tail advances.
REQ-018 Issue while full SHALL be ignored, even if a commit frees an entry the same cycle (full uses registered count).
REQ-019 CDB write SHALL occur when in_cdb_valid && entry[in_cdb_rob].busy: ready=1, value, taken, target latched; CDB to tag 0 or non-busy entry ignored.
REQ-020 Commit SHALL occur at a clock edge when rdy and entry[head].busy && entry[head].ready (registered state; a CDB write becomes committable the next cycle at earliest).
REQ-021 On commit: out_commit_reg=dest_reg, out_commit_rob=head, out_commit_value=value for one cycle; entry freed, head advances, count decrements.
REQ-022 On any non-commit cycle out_commit_reg=0, out_commit_rob=0, out_commit_value=0.
REQ-023 Mispredict = committing entry is_branch && taken != pred_taken: same cycle also out_xbp=1, out_xbp_pc=target; dest still committed.
REQ-024 On mispredict all entries SHALL be cleared (busy=0, ready=0), head=tail=1, count=0 at that edge; concurrent issue and CDB dropped.
REQ-025 out_xbp SHALL be a one-cycle pulse; out_xbp_pc=0 when out_xbp=0.
REQ-026 Simultaneous issue and commit SHALL leave count unchanged.
REQ-027 Query: out_query_readyN=1 with entry value if entry ready; else if in_cdb_valid && in_cdb_rob==query tag, ready=1 with in_cdb_value (forward); else ready=0, value=0; tag 0 returns ready=0.
REQ-028 rdy low SHALL freeze all entries/pointers and force commit/xbp outputs to idle values.

Reset
REQ-029 On rst at posedge: all entries cleared, head=tail=1, count=0, out_commit_reg=0, out_commit_rob=0, out_commit_value=0, out_xbp=0, out_xbp_pc=0; rst dominates rdy and all inputs.
REQ-030 rst mid-operation SHALL discard in-flight entries with no commit issued that cycle.

Verification
REQ-031 Issue dest=5 (tag 1), next cycle CDB tag1 value 0x1234 -> following edge out_commit_reg=5, rob=1, value=0x1234 for one cycle.
REQ-032 Issue 15 entries -> out_full=1; 16th issue ignored, out_issue_rob stays 1 (wrapped tail); commit one, next issue receives tag 1.
REQ-033 Issue tags 1,2; CDB tag2 first -> no commit; CDB tag1 -> commits tag1 then tag2 on consecutive cycles.
REQ-034 Branch tag3 pred_taken=0, CDB taken=1 target 0x100 -> at commit out_xbp=1, out_xbp_pc=0x100; next cycle count=0, out_issue_rob=1, out_full=0.
REQ-035 Query tag 4 while CDB broadcasts tag4 value 0xBEEF -> out_query_ready=1, value=0xBEEF same cycle.
REQ-036 rdy=0 with ready head for 3 cycles -> no commit, state unchanged; rdy=1 -> commit next edge; rst mid-stream -> outputs zero, count=0.
